// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state type and the divide special-case constants.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    // funct3[2] separates the divide/remainder group from the multiplies
    function automatic logic isDivOp(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-to-muldiv bundle: operands and control in, stall/result/writeback out.
interface ex_muldiv_if;

    logic                       start_i;
    logic [3:0]                 funct_i;
    logic [riscv_pkg::XLEN-1:0] rs1_i;
    logic [riscv_pkg::XLEN-1:0] rs2_i;
    logic [4:0]                 wr_reg_i;
    logic                       flush_i;
    logic                       busy_o;
    logic                       done_o;
    logic [riscv_pkg::XLEN-1:0] result_o;
    logic [4:0]                 wr_reg_o;

    modport master (
        output start_i, funct_i, rs1_i, rs2_i, wr_reg_i, flush_i,
        input  busy_o, done_o, result_o, wr_reg_o
    );

    modport slave (
        input  start_i, funct_i, rs1_i, rs2_i, wr_reg_i, flush_i,
        output busy_o, done_o, result_o, wr_reg_o
    );

endinterface

// File: rtl/ex_muldiv_core.sv
// One iteration of the unsigned datapath: shift-add multiply step or one
// restoring-division step. Purely combinational.
module ex_muldiv_core (
    input  logic        i_isDiv,
    input  logic [63:0] i_acc,
    input  logic [32:0] i_rem,
    input  logic [31:0] i_opB,
    output logic [63:0] o_acc,
    output logic [32:0] o_rem
);

    logic [32:0] w_sum;
    logic [32:0] w_shiftRem;
    logic [33:0] w_diff;

    // Multiply: acc = {partial hi, multiplier lo}, add on lsb then shift right.
    // Divide: acc[31:0] holds dividend bits shifting out / quotient bits shifting in.
    always_comb begin
        o_acc      = i_acc;
        o_rem      = i_rem;
        w_sum      = '0;
        w_shiftRem = '0;
        w_diff     = '0;
        if (!i_isDiv) begin
            w_sum = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_opB} : 33'd0);
            o_acc = {w_sum, i_acc[31:1]};
        end else begin
            w_shiftRem = {i_rem[31:0], i_acc[31]};
            w_diff     = {1'b0, w_shiftRem} - {2'b00, i_opB};
            if (!w_diff[33]) begin
                o_rem = w_diff[32:0];
                o_acc = {i_acc[63:32], i_acc[30:0], 1'b1};
            end else begin
                o_rem = w_shiftRem;
                o_acc = {i_acc[63:32], i_acc[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit with stall request and registered result.
// Define EX_MULDIV_FAST_MUL_EN for a single-cycle multiplier on the multiply ops.
module ex_muldiv
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    ex_muldiv_if.slave  bus
);

    muldiv_state_e r_state;
    logic [4:0]    r_count;
    logic [2:0]    r_op;
    logic [4:0]    r_wrReg;
    logic [63:0]   r_acc;
    logic [32:0]   r_rem;
    logic [31:0]   r_opB;
    logic          r_negRes;
    logic          r_negRem;
    logic          r_done;
    logic [31:0]   r_result;
    logic [4:0]    r_wrRegOut;

    logic [2:0]    w_f3;
    logic          w_unusedFunct;
    logic          w_aSigned;
    logic          w_bSigned;
    logic          w_negA;
    logic          w_negB;
    logic [31:0]   w_absA;
    logic [31:0]   w_absB;
    logic          w_divZero;
    logic          w_overflow;
    logic [63:0]   w_coreAcc;
    logic [32:0]   w_coreRem;
    logic [63:0]   w_prod;
    logic [31:0]   w_quot;
    logic [31:0]   w_remC;
    logic [31:0]   w_final;

    assign w_f3          = bus.funct_i[2:0];
    assign w_unusedFunct = bus.funct_i[3];

    assign w_aSigned = (w_f3 == F3_MUL) || (w_f3 == F3_MULH) || (w_f3 == F3_MULHSU)
                    || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    assign w_bSigned = (w_f3 == F3_MUL) || (w_f3 == F3_MULH)
                    || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    assign w_negA    = w_aSigned & bus.rs1_i[31];
    assign w_negB    = w_bSigned & bus.rs2_i[31];
    assign w_absA    = w_negA ? (32'd0 - bus.rs1_i) : bus.rs1_i;
    assign w_absB    = w_negB ? (32'd0 - bus.rs2_i) : bus.rs2_i;
    assign w_divZero  = isDivOp(w_f3) && (bus.rs2_i == 32'd0);
    assign w_overflow = ((w_f3 == F3_DIV) || (w_f3 == F3_REM))
                     && (bus.rs1_i == INT_MIN) && (bus.rs2_i == ALL_ONES);

`ifdef EX_MULDIV_FAST_MUL_EN
    logic signed [65:0] w_fastProd;
    logic [1:0]         w_unusedFastHi;
    assign w_fastProd     = $signed({w_aSigned & bus.rs1_i[31], bus.rs1_i})
                          * $signed({w_bSigned & bus.rs2_i[31], bus.rs2_i});
    assign w_unusedFastHi = w_fastProd[65:64];
`endif

    ex_muldiv_core u_core (
        .i_isDiv (isDivOp(r_op)),
        .i_acc   (r_acc),
        .i_rem   (r_rem),
        .i_opB   (r_opB),
        .o_acc   (w_coreAcc),
        .o_rem   (w_coreRem)
    );

    // Sign-correct the magnitude results; remainder follows the dividend sign.
    assign w_prod = r_negRes ? (64'd0 - r_acc) : r_acc;
    assign w_quot = r_negRes ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_remC = r_negRem ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

    always_comb begin
        w_final = w_prod[31:0];
        case (r_op)
            F3_MUL:                      w_final = w_prod[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod[63:32];
            F3_DIV, F3_DIVU:             w_final = w_quot;
            default:                     w_final = w_remC;
        endcase
    end

    assign bus.busy_o   = ((r_state == IDLE) && bus.start_i && !bus.flush_i)
                        || (r_state == CALC) || (r_state == DONE);
    assign bus.done_o   = r_done;
    assign bus.result_o = r_result;
    assign bus.wr_reg_o = r_wrRegOut;

    // Special cases preload acc/rem with the final answer and clear the sign
    // flags so DONE's normal selection path emits them unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= 5'd0;
            r_op       <= 3'd0;
            r_wrReg    <= 5'd0;
            r_acc      <= 64'd0;
            r_rem      <= 33'd0;
            r_opB      <= 32'd0;
            r_negRes   <= 1'b0;
            r_negRem   <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= 32'd0;
            r_wrRegOut <= 5'd0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush_i) begin
                r_state <= IDLE;
                r_count <= 5'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start_i) begin
                            r_op     <= w_f3;
                            r_wrReg  <= bus.wr_reg_i;
                            r_count  <= 5'd0;
                            r_rem    <= 33'd0;
                            r_negRes <= w_negA ^ w_negB;
                            r_negRem <= w_negA;
                            r_state  <= CALC;
                            if (isDivOp(w_f3)) begin
                                r_acc <= {32'd0, w_absA};
                                r_opB <= w_absB;
                            end else begin
                                r_acc <= {32'd0, w_absB};
                                r_opB <= w_absA;
                            end
                            if (w_divZero) begin
                                r_acc    <= {32'd0, ALL_ONES};
                                r_rem    <= {1'b0, bus.rs1_i};
                                r_negRes <= 1'b0;
                                r_negRem <= 1'b0;
                                r_state  <= DONE;
                            end else if (w_overflow) begin
                                r_acc    <= {32'd0, INT_MIN};
                                r_negRes <= 1'b0;
                                r_negRem <= 1'b0;
                                r_state  <= DONE;
                            end
`ifdef EX_MULDIV_FAST_MUL_EN
                            else if (!isDivOp(w_f3)) begin
                                r_acc    <= w_fastProd[63:0];
                                r_negRes <= 1'b0;
                                r_state  <= DONE;
                            end
`endif
                        end
                    end
                    CALC: begin
                        r_acc   <= w_coreAcc;
                        r_rem   <= w_coreRem;
                        r_count <= r_count + 5'd1;
                        if (r_count == 5'd31) begin
                            r_state <= DONE;
                        end
                    end
                    DONE: begin
                        r_result   <= w_final;
                        r_wrRegOut <= r_wrReg;
                        r_done     <= 1'b1;
                        r_state    <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: results, latency, stall window,
// special cases, flush, mid-operation reset.
module tb_ex_muldiv;

`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nPass;
    int   nFail;
    int   doneCount;
    logic [31:0] lastResult;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op, track busy/done per cycle, then verify latency, stall
    // window, result, destination and single-cycle done pulse.
    task automatic applyStimulus(input string tag, input logic [3:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] expRes, input int expLat, input bit pulseMid);
        int   doneAt;
        logic busyOk;
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.funct_i  = f;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.wr_reg_i = rd;
        doneAt = -1;
        busyOk = 1'b1;
        for (int c = 0; c < 40 && doneAt < 0; c++) begin
            @(negedge clk);
            if (bus.done_o) begin
                doneAt = c;
                if (bus.busy_o) busyOk = 1'b0;
            end else if (!bus.busy_o) begin
                busyOk = 1'b0;
            end
            @(posedge clk); #1;
            bus.start_i  = pulseMid && (c == 4);
            bus.funct_i  = 4'($urandom);
            bus.rs1_i    = $urandom;
            bus.rs2_i    = $urandom;
            bus.wr_reg_i = 5'($urandom);
        end
        bus.start_i = 1'b0;
        checkOutput({tag, "_lat"}, 32'(doneAt), 32'(expLat));
        checkOutput({tag, "_busy"}, {31'd0, busyOk}, 32'd1);
        checkOutput({tag, "_res"}, bus.result_o, expRes);
        checkOutput({tag, "_rd"}, {27'd0, bus.wr_reg_o}, {27'd0, rd});
        @(negedge clk);
        checkOutput({tag, "_pulse"}, {31'd0, bus.done_o}, 32'd0);
        lastResult = expRes;
    endtask

    initial begin
        nChecks = 0;
        nPass = 0;
        nFail = 0;
        rst_n = 1'b0;
        bus.start_i  = 1'b0;
        bus.funct_i  = 4'd0;
        bus.rs1_i    = 32'd0;
        bus.rs2_i    = 32'd0;
        bus.wr_reg_i = 5'd0;
        bus.flush_i  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("rst_done", {31'd0, bus.done_o}, 32'd0);
        checkOutput("rst_res", bus.result_o, 32'd0);
        checkOutput("rst_rd", {27'd0, bus.wr_reg_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus("mul",    4'b0000, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, MUL_LAT, 1'b0);
        applyStimulus("mulh",   4'b0001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, MUL_LAT, 1'b0);
        applyStimulus("mulhu",  4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
        applyStimulus("mulhsu", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
        applyStimulus("div",    4'b0100, 32'hFFFF_FFF9, 32'd2,        5'd5,  32'hFFFF_FFFD, 34, 1'b0);
        applyStimulus("rem",    4'b0110, 32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFF, 34, 1'b0);
        applyStimulus("divu",   4'b0101, 32'd100,      32'd7,         5'd7,  32'd14,        34, 1'b0);
        applyStimulus("remu",   4'b0111, 32'd100,      32'd7,         5'd8,  32'd2,         34, 1'b0);
        applyStimulus("div0",   4'b0100, 32'd5,        32'd0,         5'd9,  32'hFFFF_FFFF, 2,  1'b0);
        applyStimulus("rem0",   4'b0110, 32'd5,        32'd0,         5'd10, 32'd5,         2,  1'b0);
        applyStimulus("divov",  4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 2, 1'b0);
        applyStimulus("remov",  4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,        2, 1'b0);

        // Flush during CALC at S+10: idle at S+11, nothing completes
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.funct_i  = 4'b0000;
        bus.rs1_i    = 32'd3;
        bus.rs2_i    = 32'd5;
        bus.wr_reg_i = 5'd13;
        doneCount = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            if (bus.done_o) doneCount++;
        end
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("flush_done", {31'd0, bus.done_o | (doneCount != 0)}, 32'd0);
        checkOutput("flush_res", bus.result_o, lastResult);
        applyStimulus("afterflush", 4'b0101, 32'd1000, 32'd10, 5'd14, 32'd100, 34, 1'b1);

        // Asynchronous reset at S+5 of a divide
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.funct_i  = 4'b0100;
        bus.rs1_i    = 32'd50;
        bus.rs2_i    = 32'd3;
        bus.wr_reg_i = 5'd15;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("midrst_done", {31'd0, bus.done_o}, 32'd0);
        checkOutput("midrst_res", bus.result_o, 32'd0);
        checkOutput("midrst_rd", {27'd0, bus.wr_reg_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        doneCount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) doneCount++;
        end
        checkOutput("midrst_quiet", 32'(doneCount), 32'd0);

        applyStimulus("mul2", 4'b0000, 32'd7, 32'hFFFF_FFFD, 5'd16, 32'hFFFF_FFEB, MUL_LAT, 1'b0);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
